// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with load-use and multi-cycle MDU interlock.
// Optional stall-cycle performance counter enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jmp,
  input  logic        imem_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        mdu_start,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mdu_busy,
  output logic [15:0] stall_cycles
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  // The start cycle is one stall cycle, and the wait ends after cnt reaches 0,
  // so loading MDU_LAT-2 gives MDU_LAT stall cycles in total.
  localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 2);

  state_t     state;
  logic [7:0] cnt;
  logic       hazard;

  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (!hazard && mdu_start) begin
            state <= MDU_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MDU_WAIT: begin
          if (cnt == 8'd0) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_busy    = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == MDU_WAIT) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      mdu_busy    = 1'b1;
    end else if (hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (mdu_start) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
    end else if (jmp) begin
      if_id_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'h0000;
    end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl (MDU_LAT=4 and MDU_LAT=12 instances).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        jmp, imem_ready, id_use_rs, id_use_rt, ex_mem_read, mdu_start;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        pc_en_a, if_id_en_a, if_id_flush_a, id_ex_flush_a, mdu_busy_a;
  logic        pc_en_b, if_id_en_b, if_id_flush_b, id_ex_flush_b, mdu_busy_b;
  logic [15:0] stall_a, stall_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MDU_LAT(4)) dut_a (
    .clk(clk), .reset(reset), .jmp(jmp), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mdu_start(mdu_start),
    .pc_en(pc_en_a), .if_id_en(if_id_en_a), .if_id_flush(if_id_flush_a),
    .id_ex_flush(id_ex_flush_a), .mdu_busy(mdu_busy_a), .stall_cycles(stall_a)
  );

  pipeline_ctrl #(.MDU_LAT(12)) dut_b (
    .clk(clk), .reset(reset), .jmp(jmp), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mdu_start(mdu_start),
    .pc_en(pc_en_b), .if_id_en(if_id_en_b), .if_id_flush(if_id_flush_b),
    .id_ex_flush(id_ex_flush_b), .mdu_busy(mdu_busy_b), .stall_cycles(stall_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    jmp = 1'b0; imem_ready = 1'b1; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_mem_read = 1'b0; mdu_start = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    check("rst_pc_en", pc_en_a, 0);
    check("rst_if_id_en", if_id_en_a, 0);
    check("rst_if_id_flush", if_id_flush_a, 1);
    check("rst_id_ex_flush", id_ex_flush_a, 1);
    check("rst_busy", mdu_busy_a, 0);
    check("rst_stall", stall_a, 0);

    tick(); reset = 1'b0; #1;
    check("run_pc_en", pc_en_a, 1);
    check("run_if_id_en", if_id_en_a, 1);
    check("run_flushes", {if_id_flush_a, id_ex_flush_a}, 0);

    // load-use on rs, with jmp and mdu_start that must be ignored
    tick(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; jmp = 1'b1; mdu_start = 1'b1; #1;
    check("haz_pc_en", pc_en_a, 0);
    check("haz_if_id_en", if_id_en_a, 0);
    check("haz_id_ex_flush", id_ex_flush_a, 1);
    check("haz_if_id_flush", if_id_flush_a, 0);
    check("haz_busy", mdu_busy_a, 0);

    tick(); idle(); #1;
    check("post_haz_pc_en", pc_en_a, 1);
    check("post_haz_busy_a", mdu_busy_a, 0);
    check("post_haz_busy_b", mdu_busy_b, 0);

    tick(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1; #1;
    check("haz_rt_pc_en", pc_en_a, 0);

    tick(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0; #1;
    check("no_use_rt_pc_en", pc_en_a, 1);

    tick(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1; #1;
    check("r0_pc_en", pc_en_a, 1);
    check("r0_id_ex_flush", id_ex_flush_a, 0);

    tick(); idle(); jmp = 1'b1; imem_ready = 1'b0; #1;
    check("jmp_pc_en", pc_en_a, 1);
    check("jmp_if_id_en", if_id_en_a, 1);
    check("jmp_if_id_flush", if_id_flush_a, 1);
    check("jmp_id_ex_flush", id_ex_flush_a, 0);

    tick(); idle(); #1;
    check("after_jmp_flush", if_id_flush_a, 0);
    check("after_jmp_pc_en", pc_en_a, 1);

    tick(); idle(); imem_ready = 1'b0; #1;
    check("imiss_pc_en", pc_en_a, 0);
    check("imiss_if_id_en", if_id_en_a, 1);
    check("imiss_if_id_flush", if_id_flush_a, 1);

    // MDU occupancy: dut_a stalls cycles 1..4, dut_b stalls cycles 1..12
    tick(); idle(); mdu_start = 1'b1; #1;
    check("mdu1_pc_en", pc_en_a, 0);
    check("mdu1_if_id_en", if_id_en_a, 0);
    check("mdu1_id_ex_flush", id_ex_flush_a, 0);
    check("mdu1_busy", mdu_busy_a, 0);
    for (int c = 2; c <= 13; c++) begin
      tick(); idle();
      if (c == 3) begin
        jmp = 1'b1; mdu_start = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
      end
      #1;
      check($sformatf("mdu_a_c%0d_pc_en", c), pc_en_a, (c <= 4) ? 0 : 1);
      check($sformatf("mdu_a_c%0d_busy", c), mdu_busy_a, (c <= 4) ? 1 : 0);
      check($sformatf("mdu_b_c%0d_pc_en", c), pc_en_b, (c <= 12) ? 0 : 1);
      check($sformatf("mdu_b_c%0d_busy", c), mdu_busy_b, (c <= 12) ? 1 : 0);
      if (c == 3) begin
        check("mdu_wait_if_id_flush", if_id_flush_a, 0);
        check("mdu_wait_id_ex_flush", id_ex_flush_a, 1);
      end
    end

    // Asynchronous reset mid-wait: dut_b has cnt=10 in the cycle after start
    tick(); idle(); mdu_start = 1'b1;
    tick(); idle(); #1;
    check("prerst_busy_b", mdu_busy_b, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_pc_en", pc_en_b, 0);
    check("arst_if_id_en", if_id_en_b, 0);
    check("arst_if_id_flush", if_id_flush_b, 1);
    check("arst_id_ex_flush", id_ex_flush_b, 1);
    check("arst_busy", mdu_busy_b, 0);
    check("arst_stall", stall_b, 0);
    tick(); tick(); reset = 1'b0; #1;
    check("rel_pc_en", pc_en_b, 1);
    check("rel_busy", mdu_busy_b, 0);
    check("rel_stall", stall_b, 0);

`ifdef PIPELINE_CTRL_PERF_EN
    imem_ready = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_saturate", stall_a, 16'hFFFF);
    imem_ready = 1'b1;
`else
    imem_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_tied_zero", stall_a, 0);
    imem_ready = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 32, meaning: multiply/divide occupancy in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 jmp  input  1  branch/jump resolved taken in ID this cycle.
REQ-005 imem_ready  input  1  instruction memory returns valid inst this cycle.
REQ-006 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-007 id_use_rs, id_use_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-008 ex_mem_read  input  1  instruction in EX is a load.
REQ-009 ex_rd  input  5  destination register of the instruction in EX.
REQ-010 mdu_start  input  1  ID instruction is a multi-cycle mul/div.
REQ-011 pc_en  output  1  PC register update enable.
REQ-012 if_id_en  output  1  IF/ID register load enable.
REQ-013 if_id_flush  output  1  IF/ID register loads zero (bubble).
REQ-014 id_ex_flush  output  1  ID/EX register loads zero (bubble).
REQ-015 mdu_busy  output  1  MDU occupancy in progress.
REQ-016 stall_cycles  output  16  count of cycles with pc_en=0.

Function
REQ-017 FSM states SHALL be RUN and MDU_WAIT; outputs combinational from state, cnt and inputs.
REQ-018 hazard = ex_mem_read & (ex_rd!=0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-019 RUN, priority 1, hazard: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0; state stays RUN; jmp and mdu_start ignored this cycle.
REQ-020 RUN, priority 2, mdu_start (no hazard): pc_en=0, if_id_en=0, id_ex_flush=0; next state MDU_WAIT, cnt<=MDU_LAT-2.
REQ-021 RUN, priority 3, jmp (no hazard, no mdu_start): pc_en=1, if_id_en=1, if_id_flush=1.
REQ-022 RUN, priority 4, !imem_ready: pc_en=0, if_id_en=1, if_id_flush=1.
REQ-023 RUN, none of the above: pc_en=1, if_id_en=1, both flushes 0.
REQ-024 jmp together with !imem_ready in RUN: jmp rule (REQ-021) wins.
REQ-025 MDU_WAIT: pc_en=0, if_id_en=0, id_ex_flush=1, if_id_flush=0, mdu_busy=1; jmp, mdu_start, hazard ignored.
REQ-026 MDU_WAIT: cnt decrements each cycle; when cnt==0, next state RUN; total stall = MDU_LAT cycles including the REQ-020 cycle.
REQ-027 mdu_busy SHALL be 0 in RUN.
REQ-028 cnt is 8 bits, never wraps below 0.

Reset
REQ-029 Reset asserted: state=RUN, cnt=0, stall_cycles=0 immediately, independent of clk.
REQ-030 While reset asserted: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, mdu_busy=0.
REQ-031 Reset during MDU_WAIT SHALL abort the wait; first cycle after deassertion is RUN.

Configuration
REQ-032 Macro PIPELINE_CTRL_PERF_EN defined: stall_cycles increments by 1 on each clk edge where pc_en=0 and reset=0, saturating at 16'hFFFF.
REQ-033 Macro PIPELINE_CTRL_PERF_EN undefined: no counter register; stall_cycles tied to 16'h0000.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_rs=5, id_use_rs=1 for one cycle -> exactly that cycle pc_en=0, if_id_en=0, id_ex_flush=1.
REQ-035 Same as REQ-034 but ex_rd=0 -> pc_en=1, id_ex_flush=0 (r0 never hazards).
REQ-036 MDU_LAT=4, mdu_start pulse in RUN -> pc_en=0 for exactly 4 cycles, mdu_busy=1 for cycles 2-4, then RUN.
REQ-037 jmp=1, imem_ready=0 same cycle -> pc_en=1, if_id_flush=1; next cycle with jmp=0, imem_ready=1 -> no flush.
REQ-038 Reset asserted mid MDU_WAIT (cnt=10) -> outputs per REQ-030 without clk edge; after release state RUN, stall_cycles=0.
REQ-039 PERF_EN defined, 70000 consecutive stall cycles -> stall_cycles holds 16'hFFFF.
